// File: rtl/ram8_pkg.sv
// ram8_pkg -- shared constants and types for the eight-word clearable RAM.
//
// Contents:
//   DEFAULT_WIDTH  default data word width in bits
//   ADDR_W         address width (3 bits selects one of eight words)
//   NUM_WORDS      number of words in the bank
//   state_t        clear-sweep FSM state {IDLE, CLEAR}
//   decode_onehot  address to one-hot word-select decode
package ram8_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int ADDR_W        = 3;
  localparam int NUM_WORDS     = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Exactly one bit set, at the position given by the address.
  function automatic logic [NUM_WORDS-1:0] decode_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_WORDS-1:0] sel;
    sel       = '0;
    sel[addr] = 1'b1;
    return sel;
  endfunction

endpackage : ram8_pkg

// File: rtl/ram8_clr_mux8way16.sv
// Mux8Way16 -- eight-input WIDTH-bit multiplexer used as the RAM read path.
//
// Ports:
//   a..h  data inputs, selected by sel = 0..7 respectively
//   sel   3-bit select
//   out   selected input, purely combinational
module Mux8Way16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = '0;
    endcase
  end

endmodule : Mux8Way16

// File: rtl/ram8_clr_register16.sv
// register16 -- one RAM word: a WIDTH-bit register with load enable and
// asynchronous active-high reset to zero.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears the stored value
//   load   when high at a rising edge, the register captures in
//   in     data to capture
//   out    current stored value
module register16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] value_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= in;
    end
  end

  assign out = value_reg;

endmodule : register16

// File: rtl/ram8_clr.sv
// ram8_clr -- eight-word RAM with a combinational read port, a single write
// port and a self-timed clear sweep that zeroes one word per cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset; zeroes all words, aborts a sweep
//   in       write data
//   load     write enable for word[address] (ignored while busy)
//   address  word select for both read and write
//   clear    request a full-bank clear sweep (ignored while busy)
//   out      word[address], zero-latency read
//   busy     high for the eight cycles of a clear sweep
module ram8_clr
  import ram8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;

  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                wr_en;
  logic [NUM_WORDS-1:0] word_load;
  logic [WIDTH-1:0]    word_q [NUM_WORDS];

  // ---------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        // The counter naturally wraps to 0 on the edge that zeroes the
        // last word, which is also the edge that returns to IDLE.
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == ADDR_W'(NUM_WORDS - 1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy = (state_reg == CLEAR);

  // ---------------------------------------------------------------------
  // Write path: the sweep owns the single write port while busy, so any
  // user load during that time is simply dropped. A load arriving together
  // with clear in IDLE still writes, because busy is not yet high.
  // ---------------------------------------------------------------------
  assign wr_addr   = busy ? cnt_reg : address;
  assign wr_data   = busy ? '0 : in;
  assign wr_en     = busy | load;
  assign word_load = wr_en ? decode_onehot(wr_addr) : '0;

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      register16 #(
        .WIDTH(WIDTH)
      ) u_word (
        .clk   (clk),
        .reset (reset),
        .load  (word_load[gi]),
        .in    (wr_data),
        .out   (word_q[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  Mux8Way16 #(
    .WIDTH(WIDTH)
  ) u_read_mux (
    .a   (word_q[0]),
    .b   (word_q[1]),
    .c   (word_q[2]),
    .d   (word_q[3]),
    .e   (word_q[4]),
    .f   (word_q[5]),
    .g   (word_q[6]),
    .h   (word_q[7]),
    .sel (address),
    .out (out)
  );

endmodule : ram8_clr

// File: tb/tb_ram8_clr.sv
module tb_ram8_clr;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] dout;
  logic        busy;

  int checks;
  int errors;

  ram8_clr #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (dout),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    address = a;
    #1;
    check($sformatf("%s[a=%0d]", tag, a), {16'h0, dout}, {16'h0, exp});
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a;
    din     = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    din     = '0;
    load    = 1'b0;
    address = '0;
    clear   = 1'b0;

    // Reset held: every address reads 0
    #2;
    for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "in_reset");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Post-reset state
    check("busy_after_reset", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "reset_state");

    // Basic write/read; value visible only after the edge
    address = 3; din = 16'h1234; load = 1'b1;
    #1;
    check("pre_edge_a3", {16'h0, dout}, 32'h0);
    tick();
    load = 1'b0;
    rd(3, 16'h1234, "wr_a3");
    wr(7, 16'hBEEF);
    rd(7, 16'hBEEF, "wr_a7");
    rd(3, 16'h1234, "keep_a3");
    rd(0, 16'h0000, "untouched_a0");

    // Fill, then sweep while watching address 5
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hA000 + 16'(i));
    for (int i = 0; i < 8; i++) rd(3'(i), 16'hA000 + 16'(i), "fill");
    address = 5; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("sweep_busy_start", {31'h0, busy}, 32'h1);
    check("sweep_a5_start", {16'h0, dout}, 32'hA005);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("sweep_busy_e%0d", k), {31'h0, busy}, (k < 8) ? 32'h1 : 32'h0);
      check($sformatf("sweep_a5_e%0d", k), {16'h0, dout}, (k >= 6) ? 32'h0 : 32'hA005);
    end
    for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "after_sweep");

    // load and clear during a sweep are ignored
    wr(2, 16'h1111);
    clear = 1'b1;
    tick();
    check("ign_busy_start", {31'h0, busy}, 32'h1);
    address = 2; din = 16'hFFFF; load = 1'b1; clear = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("ign_busy_e%0d", k), {31'h0, busy}, (k < 8) ? 32'h1 : 32'h0);
      check($sformatf("ign_a2_e%0d", k), {16'h0, dout}, (k >= 3) ? 32'h0 : 32'h1111);
    end
    load = 1'b0; clear = 1'b0;
    tick();
    check("ign_no_restart", {31'h0, busy}, 32'h0);
    rd(2, 16'h0000, "ign_a2_final");

    // load and clear together in IDLE
    address = 0; din = 16'h5555; load = 1'b1; clear = 1'b1;
    tick();
    load = 1'b0; clear = 1'b0;
    check("both_a0_written", {16'h0, dout}, 32'h5555);
    check("both_busy", {31'h0, busy}, 32'h1);
    tick();
    check("both_a0_cleared", {16'h0, dout}, 32'h0);
    for (int k = 2; k <= 8; k++) tick();
    check("both_busy_end", {31'h0, busy}, 32'h0);

    // Reset in the middle of a sweep
    for (int i = 0; i < 4; i++) wr(3'(i), 16'h0101 * 16'(i + 1));
    for (int i = 4; i < 8; i++) wr(3'(i), 16'hC0DE);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick(); tick();
    check("mid_busy", {31'h0, busy}, 32'h1);
    address = 3;
    #1;
    check("mid_a3_uncleared", {16'h0, dout}, 32'h0404);
    #1;
    reset = 1'b1;
    #1;
    check("rst_busy_immediate", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "rst_mid");
    @(negedge clk);
    reset = 1'b0;
    wr(6, 16'h7777);
    rd(6, 16'h7777, "post_rst_load");
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    rd(4, 16'h0000, "post_rst_a4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ram8_clr
